cpu_fetch: RTL and testbench
============================

CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0200, the PC loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port mem_rd_en, output, 1, memory read strobe; data returns the next cycle.
REQ-005 SHALL have port mem_addr, output, 16, memory read address.
REQ-006 SHALL have port mem_rdata, input, 8, read data, valid the cycle after mem_rd_en.
REQ-007 SHALL have port opcode, output, 8, registered opcode driven to the combinational decoder.
REQ-008 SHALL have port instr_length, input, 2, decoder length for opcode (1/2/3 bytes).
REQ-009 SHALL have port pc_load, input, 1, redirect request from execute (jump/branch/RTS).
REQ-010 SHALL have port pc_load_value, input, 16, redirect target.
REQ-011 SHALL have port halt, input, 1, suppress new opcode fetches (HLT/WVS wait).
REQ-012 SHALL have port instr_valid, output, 1, instruction bundle valid to execute.
REQ-013 SHALL have port instr_ready, input, 1, execute accepts the bundle.
REQ-014 SHALL have port instr_pc, output, 16, address of the bundle's opcode byte.
REQ-015 SHALL have port instr_operand, output, 16, {hi,lo} operand bytes; unfetched bytes read as 0.

Function
REQ-016 SHALL implement FSM states OP_REQ, OP_CAP, LEN, LO_REQ, LO_CAP, HI_REQ, HI_CAP, VALID.
REQ-017 OP_REQ: if halt=0, SHALL assert mem_rd_en, drive mem_addr=pc, latch instr_pc=pc, clear operand, go to OP_CAP; if halt=1, SHALL stay with mem_rd_en=0.
REQ-018 OP_CAP: SHALL latch opcode=mem_rdata and set pc=pc+1, then go to LEN.
REQ-019 LEN: SHALL sample instr_length; 1 or 0 -> VALID; 2 or 3 -> LO_REQ.
REQ-020 LO_REQ/HI_REQ: SHALL assert mem_rd_en with mem_addr=pc; the CAP state SHALL latch the byte into operand[7:0]/[15:8] and set pc=pc+1.
REQ-021 LO_CAP: SHALL go to HI_REQ if the sampled length was 3, otherwise to VALID; HI_CAP -> VALID.
REQ-022 VALID: SHALL assert instr_valid; bundle outputs SHALL stay stable until instr_valid && instr_ready, then go to OP_REQ.
REQ-023 Latency from OP_REQ issue to instr_valid: 3 cycles (1-byte), 5 (2-byte), 7 (3-byte).
REQ-024 The PC SHALL wrap 16'hFFFF -> 16'h0000 on increment.
REQ-025 pc_load in any state SHALL set pc=pc_load_value and state=OP_REQ next cycle, discard any in-flight read data, and deassert instr_valid next cycle; it has priority over the handshake and over halt's hold of an in-progress fetch.
REQ-026 halt SHALL only block the OP_REQ issue; an instruction already past OP_REQ SHALL complete to VALID.
REQ-027 mem_rd_en SHALL be 0 in every state other than OP_REQ (halt=0), LO_REQ and HI_REQ.

Reset
REQ-028 On rst: pc=RESET_PC, state=OP_REQ, opcode=8'hEA (NOP), instr_pc=0, instr_operand=0, instr_valid=0, mem_rd_en=0, mem_addr=RESET_PC.
REQ-029 Reset mid-fetch SHALL abandon the partial instruction; the first fetch after release SHALL be at RESET_PC.

Structure
REQ-030 The fetch state enum and the 16-bit address width constant SHALL live in the shared cpu package.
REQ-031 The block SHALL contain no sub-module; cpu_decoder is instantiated alongside it by the parent and loops opcode -> instr_length.

Verification
REQ-032 Memory $0200=A9,$0201=05, reset release -> OP_REQ reads at $0200, instr_valid at cycle 5, opcode=A9, operand=0005, instr_pc=0200.
REQ-033 $0200=8D,34,12 with instr_ready held low for 4 cycles -> bundle {8D,1234,0200} stable throughout; after accept, next fetch at $0203.
REQ-034 pc_load=1, value=$3000 asserted during LO_CAP -> LO data discarded, next mem_addr=$3000, no instr_valid for the aborted instruction.
REQ-035 pc=$FFFF holding E8 (INX) -> bundle instr_pc=FFFF, next fetch at $0000.
REQ-036 halt=1 asserted in LEN of a 3-byte opcode -> bundle completes and is accepted, then mem_rd_en stays 0 until halt=0.
REQ-037 rst pulsed asynchronously during HI_REQ -> outputs return to reset values immediately; the first fetch after release is at $0200.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, fetch FSM states, the fetch
// bundle payload and the PC increment helper.
package cpu_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    // Opcode presented before the first real fetch completes
    localparam logic [DATA_W-1:0] OPC_NOP = 8'hEA;

    typedef enum logic [2:0] {
        OP_REQ,
        OP_CAP,
        LEN,
        LO_REQ,
        LO_CAP,
        HI_REQ,
        HI_CAP,
        VALID
    } fetch_state_e;

    // Instruction bundle handed to execute
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] opcode;
        logic [ADDR_W-1:0] operand;
    } fetch_bundle_t;

    // PC increment; wraps naturally from 16'hFFFF to 16'h0000
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/cpu_fetch.sv
// Instruction fetch unit. Reads the opcode byte, asks the external decoder
// for the instruction length, reads up to two operand bytes and presents
// {instr_pc, opcode, instr_operand} to execute with a valid/ready handshake.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   mem_rd_en/addr    read request to a synchronous memory
//   mem_rdata         read data, valid the cycle after mem_rd_en
//   opcode            registered opcode to the decoder
//   instr_length      decoder length (0/1 -> 1 byte, 2, 3)
//   pc_load/_value    redirect from execute, highest priority
//   halt              blocks new opcode fetches only
//   instr_valid/ready bundle handshake to execute
//   instr_pc          address of the bundle's opcode byte
//   instr_operand     {hi, lo} operand bytes, unfetched bytes are 0
module cpu_fetch
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0200
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] opcode,
    input  logic [1:0]        instr_length,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_value,
    input  logic              halt,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] instr_operand
);

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_pc;
    fetch_bundle_t     r_bundle;
    logic              r_need_hi;
    logic              r_valid;
    logic              w_req;

    // The read strobe is decoded from the current state so the memory sees
    // the request during the REQ cycle and returns data in the CAP cycle.
    // It is forced low while reset is asserted.
    assign w_req     = ((r_state == OP_REQ) && !halt) ||
                       (r_state == LO_REQ) || (r_state == HI_REQ);
    assign mem_rd_en = w_req && !rst;
    assign mem_addr  = r_pc;

    assign opcode        = r_bundle.opcode;
    assign instr_pc      = r_bundle.pc;
    assign instr_operand = r_bundle.operand;
    assign instr_valid   = r_valid;

    // Fetch sequencer; a redirect overrides every state and drops any
    // read data that is still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= OP_REQ;
            r_pc      <= RESET_PC;
            r_bundle  <= '{pc: '0, opcode: OPC_NOP, operand: '0};
            r_need_hi <= 1'b0;
            r_valid   <= 1'b0;
        end else if (pc_load) begin
            r_pc    <= pc_load_value;
            r_state <= OP_REQ;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                OP_REQ: begin
                    if (!halt) begin
                        r_bundle.pc      <= r_pc;
                        r_bundle.operand <= '0;
                        r_state          <= OP_CAP;
                    end
                end
                OP_CAP: begin
                    r_bundle.opcode <= mem_rdata;
                    r_pc            <= pc_inc(r_pc);
                    r_state         <= LEN;
                end
                LEN: begin
                    // Decoder answers combinationally for the new opcode
                    r_need_hi <= (instr_length == 2'd3);
                    if (instr_length >= 2'd2) begin
                        r_state <= LO_REQ;
                    end else begin
                        r_valid <= 1'b1;
                        r_state <= VALID;
                    end
                end
                LO_REQ: begin
                    r_state <= LO_CAP;
                end
                LO_CAP: begin
                    r_bundle.operand[7:0] <= mem_rdata;
                    r_pc                  <= pc_inc(r_pc);
                    if (r_need_hi) begin
                        r_state <= HI_REQ;
                    end else begin
                        r_valid <= 1'b1;
                        r_state <= VALID;
                    end
                end
                HI_REQ: begin
                    r_state <= HI_CAP;
                end
                HI_CAP: begin
                    r_bundle.operand[15:8] <= mem_rdata;
                    r_pc                   <= pc_inc(r_pc);
                    r_valid                <= 1'b1;
                    r_state                <= VALID;
                end
                VALID: begin
                    if (instr_ready) begin
                        r_valid <= 1'b0;
                        r_state <= OP_REQ;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= OP_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_fetch.sv
// Bench for cpu_fetch: synchronous memory model, stand-in decoder, and a
// scoreboard of expected bundles computed from memory contents.
module tb_cpu_fetch;
    import cpu_pkg::*;

    localparam logic [15:0] RST_PC = 16'h0200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [7:0]  opcode;
    logic [1:0]  instr_length;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_value = 16'h0000;
    logic        halt = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr_pc;
    logic [15:0] instr_operand;

    int checks = 0;
    int errors = 0;

    logic [7:0]    mem [0:65535];
    fetch_bundle_t exp_q [$];

    cpu_fetch #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .opcode        (opcode),
        .instr_length  (instr_length),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .halt          (halt),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_pc      (instr_pc),
        .instr_operand (instr_operand)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory; returns junk when not read
    always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : 8'($urandom);

    // Stand-in decoder
    function automatic logic [1:0] dec_len(input logic [7:0] op);
        case (op)
            8'hA9:   return 2'd2;
            8'h8D:   return 2'd3;
            8'hE8:   return 2'd1;
            8'hEA:   return 2'd1;
            default: return op[1:0];
        endcase
    endfunction

    assign instr_length = dec_len(opcode);

    function automatic int eff_len(input logic [7:0] op);
        logic [1:0] l;
        l = dec_len(op);
        return (l == 2'd0) ? 1 : int'(l);
    endfunction

    // Reference: the bundle an instruction at pc must produce
    function automatic fetch_bundle_t model_instr(input logic [15:0] pc);
        fetch_bundle_t b;
        logic [15:0]   a1;
        logic [15:0]   a2;
        int            n;
        a1 = pc + 16'd1;
        a2 = pc + 16'd2;
        b.pc      = pc;
        b.opcode  = mem[pc];
        b.operand = 16'h0000;
        n = eff_len(b.opcode);
        if (n >= 2) b.operand[7:0]  = mem[a1];
        if (n == 3) b.operand[15:8] = mem[a2];
        return b;
    endfunction

    task automatic push_seq(input logic [15:0] start, input int n);
        logic [15:0]   pc;
        fetch_bundle_t b;
        pc = start;
        for (int i = 0; i < n; i++) begin
            b = model_instr(pc);
            exp_q.push_back(b);
            pc = pc + 16'(eff_len(b.opcode));
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: pops on every accepted bundle and checks hold stability
    initial begin
        fetch_bundle_t cur;
        fetch_bundle_t prv;
        fetch_bundle_t e;
        logic          prv_hold;
        prv_hold = 1'b0;
        prv      = '0;
        forever begin
            @(negedge clk);
            cur = '{pc: instr_pc, opcode: opcode, operand: instr_operand};
            if (prv_hold && !rst) begin
                check("hold_valid", 64'(instr_valid), 64'd1);
                check("hold_bundle", 64'(cur), 64'(prv));
            end
            if (!rst && !pc_load && instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bundle: got %0h expected none", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("bundle", 64'(cur), 64'(e));
                end
            end
            prv_hold = !rst && !pc_load && instr_valid && !instr_ready;
            prv      = cur;
        end
    end

    task automatic check_reset_vals(input string p);
        check({p, "_rd_en"},   64'(mem_rd_en),     64'd0);
        check({p, "_addr"},    64'(mem_addr),      64'(RST_PC));
        check({p, "_opcode"},  64'(opcode),        64'hEA);
        check({p, "_pc"},      64'(instr_pc),      64'd0);
        check({p, "_operand"}, 64'(instr_operand), 64'd0);
        check({p, "_valid"},   64'(instr_valid),   64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pc_load = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic redirect(input logic [15:0] tgt, input int n);
        @(posedge clk);
        #1;
        pc_load       = 1'b1;
        pc_load_value = tgt;
        exp_q.delete();
        push_seq(tgt, n);
        @(posedge clk);
        #1 pc_load = 1'b0;
    endtask

    // Waits (bounded) for the next read strobe and checks its address
    task automatic wait_read(input logic [15:0] addr, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_rd_en && n < 30);
        check({name, "_seen"}, 64'(mem_rd_en), 64'd1);
        check({name, "_addr"}, 64'(mem_addr), 64'(addr));
    endtask

    // Cycles from the issuing negedge until instr_valid
    task automatic wait_valid(input int lat, input string name);
        int n;
        n = 0;
        while (!instr_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(n), 64'(lat));
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            seen;
        int            cyc;
        int            limit;
        logic [15:0]   tgt;
        fetch_bundle_t hold_exp;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        // Two-byte instruction straight out of reset
        mem[16'h0200] = 8'hA9;
        mem[16'h0201] = 8'h05;
        do_reset();
        push_seq(RST_PC, 1);
        instr_ready = 1'b1;
        wait_read(16'h0200, "first_read");
        wait_valid(5, "lat_2byte");
        @(posedge clk);
        #1 instr_ready = 1'b0;
        check("first_drained", 64'(exp_q.size()), 64'd0);

        // Three-byte instruction held under backpressure
        mem[16'h0200] = 8'h8D;
        mem[16'h0201] = 8'h34;
        mem[16'h0202] = 8'h12;
        do_reset();
        push_seq(RST_PC, 1);
        wait_read(16'h0200, "bp_read");
        wait_valid(7, "lat_3byte");
        hold_exp = '{pc: 16'h0200, opcode: 8'h8D, operand: 16'h1234};
        repeat (4) begin
            @(negedge clk);
            check("bp_stable", 64'({instr_valid, instr_pc, opcode, instr_operand}),
                  64'({1'b1, hold_exp}));
        end
        @(posedge clk);
        #1 instr_ready = 1'b1;
        @(posedge clk);
        #1 instr_ready = 1'b0;
        check("bp_drained", 64'(exp_q.size()), 64'd0);
        wait_read(16'h0203, "bp_next_fetch");

        // Redirect while the low operand byte is being captured
        mem[16'h3000] = 8'hA9;
        mem[16'h3001] = 8'h77;
        do_reset();
        push_seq(RST_PC, 1);
        instr_ready = 1'b1;
        wait_read(16'h0200, "redir_op_read");
        wait_read(16'h0201, "redir_lo_read");
        @(posedge clk);
        #1;
        pc_load       = 1'b1;
        pc_load_value = 16'h3000;
        exp_q.delete();
        push_seq(16'h3000, 1);
        @(negedge clk);
        check("redir_valid_low", 64'(instr_valid), 64'd0);
        @(posedge clk);
        #1 pc_load = 1'b0;
        @(negedge clk);
        check("redir_next_rd_en", 64'(mem_rd_en), 64'd1);
        check("redir_next_addr", 64'(mem_addr), 64'h3000);
        check("redir_valid_gone", 64'(instr_valid), 64'd0);
        wait_valid(5, "redir_lat");
        @(posedge clk);
        #1 instr_ready = 1'b0;
        check("redir_drained", 64'(exp_q.size()), 64'd0);

        // PC wrap at the top of memory
        mem[16'hFFFF] = 8'hE8;
        instr_ready = 1'b1;
        redirect(16'hFFFF, 1);
        wait_read(16'hFFFF, "wrap_read");
        wait_valid(3, "lat_1byte");
        @(posedge clk);
        #1 instr_ready = 1'b0;
        check("wrap_drained", 64'(exp_q.size()), 64'd0);
        wait_read(16'h0000, "wrap_next_fetch");

        // Halt raised after the opcode is in; instruction must still finish
        mem[16'h0400] = 8'h8D;
        mem[16'h0401] = 8'h11;
        mem[16'h0402] = 8'h22;
        instr_ready = 1'b1;
        redirect(16'h0400, 1);
        wait_read(16'h0400, "halt_read");
        @(posedge clk);
        @(posedge clk);
        #1 halt = 1'b1;
        wait_drain("halt_drained");
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_rd_en || instr_valid) seen = 1;
        end
        check("halt_idle", 64'(seen), 64'd0);
        @(posedge clk);
        #1 halt = 1'b0;
        @(negedge clk);
        check("halt_resume_rd_en", 64'(mem_rd_en), 64'd1);
        check("halt_resume_addr", 64'(mem_addr), 64'h0403);
        instr_ready = 1'b0;

        // Asynchronous reset during the high operand read
        mem[16'h0500] = 8'h8D;
        mem[16'h0501] = 8'hAB;
        mem[16'h0502] = 8'hCD;
        redirect(16'h0500, 1);
        wait_read(16'h0500, "arst_op_read");
        wait_read(16'h0501, "arst_lo_read");
        wait_read(16'h0502, "arst_hi_read");
        #2 rst = 1'b1;
        #1 check_reset_vals("arst");
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        push_seq(RST_PC, 1);
        instr_ready = 1'b1;
        @(negedge clk);
        check("arst_first_rd_en", 64'(mem_rd_en), 64'd1);
        check("arst_first_addr", 64'(mem_addr), 64'(RST_PC));
        wait_valid(7, "arst_lat");
        @(posedge clk);
        #1 instr_ready = 1'b0;
        check("arst_drained", 64'(exp_q.size()), 64'd0);

        // Random streams with backpressure, halt and occasional aborts
        for (int seg = 0; seg < 12; seg++) begin
            tgt   = 16'(32'h0600 + $urandom_range(0, 32'h0800));
            limit = (seg % 3 == 2) ? int'($urandom_range(4, 60)) : 3000;
            redirect(tgt, 12);
            cyc = 0;
            while (exp_q.size() != 0 && cyc < limit) begin
                instr_ready = ($urandom_range(0, 99) < 70);
                halt        = ($urandom_range(0, 99) < 15);
                @(posedge clk);
                #1;
                cyc++;
            end
            instr_ready = 1'b0;
            halt        = 1'b0;
            if (seg % 3 != 2) check("rand_drained", 64'(exp_q.size()), 64'd0);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
